apu_frame_sequencer: RTL
========================

# apu_frame_sequencer

Single-clock timing controller for the sound subsystem: it produces every timebase the channels need as one-cycle enable strobes in the `ac97_bitclk` domain. It replaces the chain of derived clocks (frame, sweep, envelope, length, channel frequency clocks), so all channel logic runs on one clock. The frame step follows the Game Boy 8-step pattern. The channel-frequency rates are exact on average: 131072 Hz and 65536 Hz derived from a 12.288 MHz clock.

## Interface
Parameters:
- `FRAME_DIV`, 24000 — `ac97_bitclk` cycles per 512 Hz frame step.
- `FREQ_NUM`, 4 — fractional increment for the 131072 Hz tick.
- `FREQ_DEN`, 375 — fractional modulus for the 131072 Hz tick (4/375 × 12.288 MHz).

Ports:
- `ac97_bitclk`  in  1  sole clock, 12.288 MHz.
- `reset_n`  in  1  reset, asynchronous, active-low.
- `master_sound_enable`  in  1  level; low holds all state cleared and suppresses strobes.
- `seq_restart`  in  1  one-cycle pulse; restarts the frame prescaler and sets the step to 0.
- `length_tick`  out  1  256 Hz strobe.
- `sweep_tick`  out  1  128 Hz strobe.
- `env_tick`  out  1  64 Hz strobe.
- `ch12_freq_tick`  out  1  131072 Hz average strobe.
- `ch3_freq_tick`  out  1  65536 Hz strobe, on every second `ch12_freq_tick`.
- `frame_step`  out  3  current step, 0–7.

## Operation
- **Frame prescaler.** `frame_cnt` counts 0 to `FRAME_DIV`−1 while enabled.
  - At terminal count it wraps to 0 and raises an internal frame event for the current `frame_step`.
  - `frame_step` then increments mod 8.
- **Strobes per step**, decoded from the step being left:
  - `length_tick` on steps 0, 2, 4, 6.
  - `sweep_tick` on steps 2 and 6.
  - `env_tick` on step 7.
- **Frequency accumulator.** `acc` has width clog2(`FREQ_DEN`+`FREQ_NUM`).
  - Each enabled cycle: if `acc`+`FREQ_NUM` ≥ `FREQ_DEN`, then `acc` ← `acc`+`FREQ_NUM`−`FREQ_DEN` and a `ch12` event fires; otherwise `acc` ← `acc`+`FREQ_NUM`.
  - No drift: exactly `FREQ_NUM` events per `FREQ_DEN` cycles.
- **ch3 divider.** Toggle bit `ch3_ph` flips on each `ch12` event. `ch3_freq_tick` fires on the `ch12` event where `ch3_ph` is 1 before the flip.
- **`master_sound_enable` low:**
  - `frame_cnt`, `frame_step`, `acc` and `ch3_ph` are held at 0, and all strobes are 0.
  - On re-enable, counting resumes from 0, so the first strobe is `length_tick` (step 0).
- **`seq_restart`:**
  - Clears `frame_cnt` and `frame_step` only. It does not touch `acc` or `ch3_ph`.
  - If it coincides with a terminal count, restart wins: no frame strobe that cycle and `frame_step`=0.
  - It has no effect while disabled.
- **Reset.** Asynchronous assertion clears all state and outputs immediately, including mid-frame.

## Timing
- All strobes are registered and last exactly one cycle.
- A strobe is high in the cycle after the edge on which its event was detected.
- First `length_tick` after enable rises (or after reset release with enable high) is high during cycle `FRAME_DIV`+1, counting the first enabled edge as cycle 1.
- `frame_step` updates on the same edge that registers the frame strobes; `frame_step` and the strobe become visible together.
- **Reset values:** all tick outputs 0, `frame_step` 0.
- Coincident `ch12` and frame events are independent and may both be high in the same cycle.

## Structure
- Package `apu_timing_pkg`:
  - default divisor constants (`FRAME_DIV`, `FREQ_NUM`, `FREQ_DEN`);
  - step-decode masks `LEN_STEPS`=8'b0101_0101, `SWEEP_STEPS`=8'b0100_0100, `ENV_STEPS`=8'b1000_0000, bit index = step.
- One sub-module, `rate_accumulator` (parameters `NUM`, `DEN`; inputs `clear`, `enable`; output `event`).
  - Instantiated twice: frame prescaler with `NUM`=1, `DEN`=`FRAME_DIV`; frequency accumulator with `NUM`=`FREQ_NUM`, `DEN`=`FREQ_DEN`.

## Test plan
- **Frame cadence.** Reset, enable high for 8×24000 cycles:
  - exactly 4 `length_tick`, 2 `sweep_tick`, 1 `env_tick`;
  - first `length_tick` at cycle 24001;
  - `env_tick` coincides with `frame_step` changing 7→0.
- **Fractional rate.**
  - Over 375 enabled cycles: exactly 4 `ch12_freq_tick` and 2 `ch3_freq_tick`.
  - Over 375×1000 cycles: 4000 and 2000 respectively.
  - Inter-tick gaps are only ever 93 or 94 cycles.
- **Disable mid-frame.** Drop `master_sound_enable` at step 5 mid-count:
  - all strobes stop and `frame_step` reads 0 while disabled;
  - after re-enable the first frame strobe is `length_tick` at cycle 24001.
- **Restart collision.** Pulse `seq_restart` on the terminal-count cycle of step 6:
  - no `length_tick` or `sweep_tick` that cycle;
  - `frame_step`=0;
  - next `length_tick` 24000 cycles later;
  - `ch12` tick spacing is undisturbed.
- **Async reset.** Assert `reset_n` low between clock edges during a strobe cycle:
  - strobe drops immediately without a clock edge;
  - after release, behaviour matches the first scenario.
- **Small-parameter sweep.** `FRAME_DIV`=4, `FREQ_NUM`=3, `FREQ_DEN`=7: step sequence and event counts match a reference model over 10000 cycles.

Source files
------------

// File: rtl/apu_timing_pkg.sv
// Shared timing constants for the APU frame sequencer: default divisors and
// the per-step strobe decode masks (bit index = frame step being left).
package apu_timing_pkg;

    localparam int FRAME_DIV = 24000;  // clocks per 512 Hz frame step
    localparam int FREQ_NUM  = 4;      // 4/375 x 12.288 MHz = 131072 Hz
    localparam int FREQ_DEN  = 375;

    localparam logic [7:0] LEN_STEPS   = 8'b0101_0101;
    localparam logic [7:0] SWEEP_STEPS = 8'b0100_0100;
    localparam logic [7:0] ENV_STEPS   = 8'b1000_0000;

    // Frame step advances mod 8; the 3-bit wrap does the modulus.
    function automatic logic [2:0] next_step(input logic [2:0] step);
        return step + 3'd1;
    endfunction

endpackage

// File: rtl/apu_frame_sequencer_rate_accumulator.sv
// Fractional rate generator: adds NUM per enabled cycle modulo DEN and flags
// each wrap, giving exactly NUM events every DEN enabled cycles. With NUM=1
// it degenerates into a plain 0..DEN-1 prescaler with terminal-count flag.
module rate_accumulator #(
    parameter int NUM = 1,
    parameter int DEN = 2
) (
    input  logic clk_i,
    input  logic rst_ni,
    input  logic clear_i,
    input  logic enable_i,
    output logic event_o
);

    localparam int W = $clog2(DEN + NUM);

    logic [W-1:0] acc_q;
    logic [W-1:0] acc_d;
    logic [W:0]   sum;
    logic         wrap;

    // Next accumulator value; clear has priority and suppresses the event.
    always_comb begin
        sum     = {1'b0, acc_q} + (W+1)'(NUM);
        wrap    = (sum >= (W+1)'(DEN));
        acc_d   = acc_q;
        event_o = 1'b0;
        if (clear_i) begin
            acc_d = '0;
        end else if (enable_i) begin
            event_o = wrap;
            acc_d   = wrap ? W'(sum - (W+1)'(DEN)) : W'(sum);
        end
    end

    // Accumulator register.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            acc_q <= '0;
        end else begin
            acc_q <= acc_d;
        end
    end

endmodule

// File: rtl/apu_frame_sequencer.sv
// APU frame sequencer: generates every sound-channel timebase as a one-cycle
// registered strobe in the ac97_bitclk domain (frame-step strobes for
// length/sweep/envelope, plus the 131072 Hz and 65536 Hz channel ticks).
module apu_frame_sequencer #(
    parameter int FRAME_DIV = apu_timing_pkg::FRAME_DIV,
    parameter int FREQ_NUM  = apu_timing_pkg::FREQ_NUM,
    parameter int FREQ_DEN  = apu_timing_pkg::FREQ_DEN
) (
    input  logic       ac97_bitclk,
    input  logic       reset_n,
    input  logic       master_sound_enable,
    input  logic       seq_restart,
    output logic       length_tick,
    output logic       sweep_tick,
    output logic       env_tick,
    output logic       ch12_freq_tick,
    output logic       ch3_freq_tick,
    output logic [2:0] frame_step
);

    logic       frame_evt;
    logic       ch12_evt;
    logic       frame_clear;
    logic       freq_clear;

    logic [2:0] step_q, step_d;
    logic       ch3_ph_q, ch3_ph_d;
    logic       len_q, len_d;
    logic       sweep_q, sweep_d;
    logic       env_q, env_d;
    logic       ch12_q, ch12_d;
    logic       ch3_q, ch3_d;

    // Restart only touches the frame prescaler; the frequency path keeps
    // running so channel pitch is not disturbed by a sequencer restart.
    assign frame_clear = ~master_sound_enable | seq_restart;
    assign freq_clear  = ~master_sound_enable;

    rate_accumulator #(
        .NUM (1),
        .DEN (FRAME_DIV)
    ) u_frame_prescaler (
        .clk_i    (ac97_bitclk),
        .rst_ni   (reset_n),
        .clear_i  (frame_clear),
        .enable_i (master_sound_enable),
        .event_o  (frame_evt)
    );

    rate_accumulator #(
        .NUM (FREQ_NUM),
        .DEN (FREQ_DEN)
    ) u_freq_accumulator (
        .clk_i    (ac97_bitclk),
        .rst_ni   (reset_n),
        .clear_i  (freq_clear),
        .enable_i (master_sound_enable),
        .event_o  (ch12_evt)
    );

    // Step advance and strobe decode from the step being left.
    always_comb begin
        step_d   = step_q;
        ch3_ph_d = ch3_ph_q;
        len_d    = 1'b0;
        sweep_d  = 1'b0;
        env_d    = 1'b0;
        ch12_d   = 1'b0;
        ch3_d    = 1'b0;
        if (!master_sound_enable) begin
            step_d   = 3'd0;
            ch3_ph_d = 1'b0;
        end else begin
            if (seq_restart) begin
                step_d = 3'd0;
            end else if (frame_evt) begin
                step_d  = apu_timing_pkg::next_step(step_q);
                len_d   = apu_timing_pkg::LEN_STEPS[step_q];
                sweep_d = apu_timing_pkg::SWEEP_STEPS[step_q];
                env_d   = apu_timing_pkg::ENV_STEPS[step_q];
            end
            if (ch12_evt) begin
                ch12_d   = 1'b1;
                ch3_d    = ch3_ph_q;
                ch3_ph_d = ~ch3_ph_q;
            end
        end
    end

    // Step, divider phase and output strobe registers.
    always_ff @(posedge ac97_bitclk or negedge reset_n) begin
        if (!reset_n) begin
            step_q   <= 3'd0;
            ch3_ph_q <= 1'b0;
            len_q    <= 1'b0;
            sweep_q  <= 1'b0;
            env_q    <= 1'b0;
            ch12_q   <= 1'b0;
            ch3_q    <= 1'b0;
        end else begin
            step_q   <= step_d;
            ch3_ph_q <= ch3_ph_d;
            len_q    <= len_d;
            sweep_q  <= sweep_d;
            env_q    <= env_d;
            ch12_q   <= ch12_d;
            ch3_q    <= ch3_d;
        end
    end

    assign length_tick    = len_q;
    assign sweep_tick     = sweep_q;
    assign env_tick       = env_q;
    assign ch12_freq_tick = ch12_q;
    assign ch3_freq_tick  = ch3_q;
    assign frame_step     = step_q;

endmodule
